// File: rtl/punc_fetch_pkg.sv
// Shared types and defaults for the PUnC instruction-fetch stage.
package punc_fetch_pkg;

  // Fetch FSM encoding; values are visible on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_VALID = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_e;

  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam int          DEF_TIMEOUT  = 16;

  // Width of a counter that must reach TIMEOUT-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/punc_pc_reg.sv
// Program counter: clear beats load beats increment; hold freezes load/inc only.
module punc_pc_reg #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_data,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  // Next-PC selection; increment wraps naturally at 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (clr)       pc_d = RESET_PC;
    else if (hold) pc_d = pc_q;
    else if (load) pc_d = load_data;
    else if (inc)  pc_d = pc_q + ADDR_W'(1);
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/punc_fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, runs one req/ack read per fetch.
// Handshake: mem_req is held high with a stable mem_addr until the first
// cycle where mem_ack=1; that cycle completes the read and mem_req drops on
// the next cycle, so each request consumes exactly one ack.
module punc_fetch_unit
  import punc_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC[ADDR_W-1:0],
  parameter int                TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              pc_clr,
  input  logic              pc_w_en,
  input  logic [ADDR_W-1:0] pc_w_data,
  input  logic              pc_inc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err,
  output fetch_state_e      dbg_state
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [DATA_W-1:0] ir_d, ir_q;
  logic              ir_valid_d, ir_valid_q;
  logic              err_d, err_q;

  // A read is outstanding in WAIT and in DRAIN (aborted but still unacked).
  assign mem_req   = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign busy      = mem_req;
  assign mem_addr  = addr_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = err_q;
  assign dbg_state = state_q;

  punc_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .hold      (busy),
    .clr       (pc_clr),
    .load      (pc_w_en),
    .load_data (pc_w_data),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // Next-state logic for the fetch FSM, IR, address latch and timeout counter.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE, ST_VALID: begin
        if (pc_clr) begin
          // Clear wins over a same-cycle fetch request.
          ir_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (fetch_req) begin
          addr_d     = pc;   // pre-update PC
          cnt_d      = '0;
          ir_valid_d = 1'b0;
          state_d    = ST_WAIT;
        end else if (pc_w_en || pc_inc) begin
          // IR no longer matches the PC once control moves it.
          ir_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (mem_ack && pc_clr) begin
          // Read finished but the PC was cleared: discard the word.
          state_d = ST_IDLE;
        end else if (mem_ack) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          state_d    = ST_VALID;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (pc_clr) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_ack) begin
          ir_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_punc_fetch_unit.sv
// Bench for punc_fetch_unit: table of fetch transactions plus hand sequences.
module tb_punc_fetch_unit;
  import punc_fetch_pkg::*;

  localparam int W = 16;

  logic         clk, rst;
  logic         fetch_req, pc_clr, pc_w_en, pc_inc, mem_ack;
  logic [W-1:0] pc_w_data, mem_rdata;
  logic         mem_req, ir_valid, busy, fetch_err;
  logic [W-1:0] mem_addr, pc, ir;
  fetch_state_e dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic         irv_prev = 1'b0;

  punc_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .pc_clr    (pc_clr),
    .pc_w_en   (pc_w_en),
    .pc_w_data (pc_w_data),
    .pc_inc    (pc_inc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .pc        (pc),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .busy      (busy),
    .fetch_err (fetch_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_req = 0; pc_clr = 0; pc_w_en = 0; pc_inc = 0; mem_ack = 0;
    pc_w_data = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  // Scoreboard: every rising ir_valid must deliver the oldest queued word.
  always @(negedge clk) begin
    if (!rst && ir_valid && !irv_prev) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_unexpected: got ir %h with empty queue", ir);
      end else begin
        chk("sb_ir", ir, exp_q.pop_front());
      end
    end
    irv_prev = ir_valid;
  end

  // Driver: one fetch at addr_exp, ack after 'delay' idle WAIT cycles.
  task automatic do_fetch(input logic [W-1:0] addr_exp, input int delay, input logic [W-1:0] data);
    exp_q.push_back(data);
    fetch_req = 1; tick(); fetch_req = 0;
    chk("fetch_mem_req", {15'd0, mem_req}, 16'd1);
    chk("fetch_addr", mem_addr, addr_exp);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("wait_addr", mem_addr, addr_exp);
    end
    mem_ack = 1; mem_rdata = data; tick(); mem_ack = 0;
    chk("done_valid", {15'd0, ir_valid}, 16'd1);
    chk("done_busy", {15'd0, busy}, 16'd0);
  endtask

  typedef struct {
    logic         load;
    logic [W-1:0] target;
    int           delay;
    logic [W-1:0] data;
  } vec_t;

  vec_t vecs[4];
  int   cyc;

  initial begin
    vecs[0] = '{1'b0, 16'h0000, 2, 16'h1234};
    vecs[1] = '{1'b1, 16'h3000, 0, 16'h5A5A};
    vecs[2] = '{1'b1, 16'h00FF, 5, 16'hC0DE};
    vecs[3] = '{1'b1, 16'hFFFF, 1, 16'h0F0F};

    rst = 0;
    do_reset();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_irv", {15'd0, ir_valid}, 16'd0);
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_err", {15'd0, fetch_err}, 16'd0);
    chk("rst_state", {13'd0, dbg_state}, {13'd0, ST_IDLE});

    // Table of fetch transactions; a PC load in VALID precedes each later one.
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].load) begin
        pc_w_en = 1; pc_w_data = vecs[v].target; tick(); pc_w_en = 0;
        chk("load_irv_drop", {15'd0, ir_valid}, 16'd0);
        chk("load_pc", pc, vecs[v].target);
      end
      do_fetch(vecs[v].target, vecs[v].delay, vecs[v].data);
    end

    // Wrap: PC is FFFF here.
    pc_inc = 1; tick(); pc_inc = 0;
    chk("inc_wrap", pc, 16'h0000);
    chk("inc_irv_drop", {15'd0, ir_valid}, 16'd0);

    // Priority: clr > load > inc.
    pc_w_en = 1; pc_w_data = 16'h1111; tick();
    pc_inc = 1; pc_w_data = 16'h0042; pc_clr = 1; tick(); pc_clr = 0;
    chk("prio_clr", pc, 16'h0000);
    tick(); pc_inc = 0; pc_w_en = 0;
    chk("prio_load", pc, 16'h0042);

    // PC commands ignored while a fetch is outstanding.
    exp_q.push_back(16'hA5A5);
    fetch_req = 1; tick(); fetch_req = 0;
    pc_w_en = 1; pc_w_data = 16'h5555; pc_inc = 1; tick(); tick();
    pc_w_en = 0; pc_inc = 0;
    chk("wait_pc_hold", pc, 16'h0042);
    chk("wait_addr_hold", mem_addr, 16'h0042);
    mem_ack = 1; mem_rdata = 16'hA5A5; tick(); mem_ack = 0;
    chk("wait_done_irv", {15'd0, ir_valid}, 16'd1);

    // Aborted fetch: pc_clr in WAIT, late ack is dropped.
    pc_w_en = 1; pc_w_data = 16'h0100; tick(); pc_w_en = 0;
    fetch_req = 1; tick(); fetch_req = 0;
    pc_clr = 1; tick(); pc_clr = 0;
    chk("drain_state", {13'd0, dbg_state}, {13'd0, ST_DRAIN});
    chk("drain_busy", {15'd0, busy}, 16'd1);
    chk("drain_addr", mem_addr, 16'h0100);
    chk("drain_pc", pc, 16'h0000);
    tick(); tick();
    mem_ack = 1; mem_rdata = 16'hBEEF; tick(); mem_ack = 0;
    chk("drain_ir", ir, 16'hA5A5);
    chk("drain_irv", {15'd0, ir_valid}, 16'd0);
    chk("drain_idle", {13'd0, dbg_state}, {13'd0, ST_IDLE});
    chk("drain_req", {15'd0, mem_req}, 16'd0);

    // Stray ack in IDLE is ignored.
    mem_ack = 1; mem_rdata = 16'hDEAD; tick(); mem_ack = 0;
    chk("stray_ir", ir, 16'hA5A5);
    chk("stray_state", {13'd0, dbg_state}, {13'd0, ST_IDLE});

    // Timeout: no ack after a fetch.
    fetch_req = 1; tick(); fetch_req = 0;
    cyc = 0;
    while (!fetch_err && cyc < 40) begin
      tick(); cyc++;
    end
    chk("to_cycles", cyc[15:0], 16'd16);
    chk("to_err", {15'd0, fetch_err}, 16'd1);
    chk("to_req", {15'd0, mem_req}, 16'd0);
    fetch_req = 1; tick(); fetch_req = 0;
    chk("err_no_fetch", {15'd0, mem_req}, 16'd0);
    chk("err_state", {13'd0, dbg_state}, {13'd0, ST_ERR});
    pc_w_en = 1; pc_w_data = 16'h0777; tick(); pc_w_en = 0;
    chk("err_pc_load", pc, 16'h0777);
    do_reset();
    chk("rst_clears_err", {15'd0, fetch_err}, 16'd0);
    chk("rst_pc2", pc, 16'h0000);

    tick();
    chk("sb_empty", exp_q.size(), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/punc_fetch_unit.md
Name: punc_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the PUnC control FSM. It owns the PC and the IR, issues a request/acknowledge read to instruction memory, and presents a held IR with a valid flag to control. It accepts PC clear, load and increment commands from control and datapath. A bounded ack timeout raises a sticky error.

Parameters:
ADDR_W, 16, PC and memory address width.
DATA_W, 16, instruction and IR width.
RESET_PC, 16'h0000, PC value after rst or pc_clr.
TIMEOUT, 16, maximum WAIT cycles without mem_ack before error; legal range 2..255.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  synchronous, active-high reset.
fetch_req  in  1  control requests a fetch at the current PC.
pc_clr  in  1  PC <= RESET_PC.
pc_w_en  in  1  PC <= pc_w_data.
pc_w_data  in  ADDR_W  branch/jump target from the ALU.
pc_inc  in  1  PC <= PC+1.
mem_req  out  1  read request, held until ack.
mem_addr  out  ADDR_W  read address, stable while mem_req=1.
mem_ack  in  1  read data valid this cycle.
mem_rdata  in  DATA_W  instruction word.
pc  out  ADDR_W  current PC, registered.
ir  out  DATA_W  instruction register, registered.
ir_valid  out  1  ir holds the word fetched from the current fetch.
busy  out  1  high in WAIT or DRAIN.
fetch_err  out  1  sticky ack-timeout error.

Behaviour:
- Reset (rst=1 at posedge, overrides everything):
  - state=IDLE, pc=RESET_PC, ir=0, ir_valid=0, fetch_err=0, timeout count=0, addr reg=0.
  - Outputs mem_req=0 and busy=0.
- States: IDLE, WAIT, VALID, DRAIN, ERR.
  - mem_req = (state==WAIT or DRAIN); decoded from registered state.
  - busy = mem_req.
  - mem_addr = addr reg.
- PC update priority: pc_clr > pc_w_en > pc_inc.
  - The update applies in IDLE, VALID and ERR.
  - In WAIT and DRAIN, pc_w_en and pc_inc are ignored and the PC holds.
  - pc_clr always applies.
- PC arithmetic: increment is mod 2^ADDR_W, so 16'hFFFF -> 16'h0000.
- IDLE or VALID with fetch_req=1:
  - addr reg <= pc, using the pre-update PC if a PC command arrives in the same cycle.
  - count <= 0, ir_valid <= 0, next state WAIT.
  - Simultaneous pc_clr wins: the PC is cleared, no fetch starts, state goes to IDLE.
- WAIT:
  - On mem_ack: ir <= mem_rdata, ir_valid <= 1, next state VALID. mem_req falls the cycle after ack, so each request accepts exactly one ack.
  - No ack: count increments.
  - Timeout: when count==TIMEOUT-1 with no ack, fetch_err <= 1 and next state ERR.
  - fetch_req is ignored.
  - pc_clr: PC <= RESET_PC, next state DRAIN.
- DRAIN (aborted fetch):
  - mem_req stays high with the old addr reg; the timeout counter continues.
  - On ack, the data is discarded: ir unchanged, ir_valid=0, next state IDLE.
  - On timeout: fetch_err <= 1, next state ERR.
- VALID:
  - ir and ir_valid hold.
  - ir_valid clears on any of: fetch_req accepted, pc_w_en, pc_clr, or pc_inc while ir_valid=1. Control pulses pc_inc in decode, after the IR is used.
  - A new fetch_req moves to WAIT.
- ERR: terminal until rst. fetch_req is ignored and mem_req=0; PC commands still apply.
- mem_ack outside WAIT/DRAIN is ignored.
- Latency: fetch_req at cycle t puts mem_req high at t+1. An ack at cycle t+k gives ir_valid=1 at t+k+1.

Decomposition:
- Package punc_fetch_pkg:
  - State enum localparams (IDLE=0, WAIT=1, VALID=2, DRAIN=3, ERR=4; 3-bit).
  - Default RESET_PC and TIMEOUT.
  - Counter-width helper (clog2 of TIMEOUT).
- One sub-module, punc_pc_reg: the PC register with clr/load/inc priority and a hold input driven by busy. Instantiated once.

Test Plan:
- Reset then fetch_req with ack 2 cycles later and mem_rdata=16'h1234 -> mem_addr=16'h0000 while mem_req=1; ir=16'h1234, ir_valid=1 one cycle after ack; busy low.
- pc_w_en with pc_w_data=16'h3000 in VALID, then fetch_req -> ir_valid drops; next mem_addr=16'h3000.
- pc=16'hFFFF, pc_inc -> pc=16'h0000. Same cycle: pc_inc, pc_w_en (16'h0042) and pc_clr all set -> pc=RESET_PC; with only pc_inc and pc_w_en set -> pc=16'h0042.
- pc_w_en=1 and pc_inc=1 while in WAIT -> pc unchanged and mem_addr stable; ack completes normally.
- pc_clr in WAIT, ack 3 cycles later with 16'hBEEF -> ir not updated, ir_valid=0, state IDLE, pc=RESET_PC.
- No ack for 16 cycles after fetch_req -> fetch_err=1, mem_req=0; a later fetch_req does nothing; rst clears fetch_err.
